cpu_controller_mc: RTL and testbench

Multi-cycle control FSM for the simple register-file/ALU datapath. It is the next generation of the datapath controller and adds several behaviours. The instruction is latched at start, so its inputs are free to change afterwards. It adds LDR/STR with a memory request/acknowledge handshake, a parametrised memory timeout, HALT, and explicit illegal-instruction reporting. It sits between the instruction decoder and the datapath/memory interface, and all outputs are Moore outputs decoded from the state register.

---
 rtl/cpu_controller_mc.sv | 151 +++++++++++++++
 tb/tb_cpu_controller_mc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller_mc.sv
// Multi-cycle control FSM for the register-file/ALU datapath with LDR/STR memory
// handshake, memory timeout, HALT and illegal-instruction reporting. Moore outputs only.
module cpu_controller_mc #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned STATUS_ALL  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [1:0] ALU_op,
    input  logic       mem_ack,
    output logic       waiting,
    output logic       halted,
    output logic       err,
    output logic [1:0] reg_sel,
    output logic [1:0] wb_sel,
    output logic       w_en,
    output logic       en_A,
    output logic       en_B,
    output logic       en_C,
    output logic       en_status,
    output logic       en_addr,
    output logic       sel_A,
    output logic       sel_B,
    output logic       mem_req,
    output logic       mem_wr,
    output logic [3:0] state_dbg
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [4:0] I_MOVI = 5'b11010;
    localparam logic [4:0] I_MOV  = 5'b11000;
    localparam logic [4:0] I_ADD  = 5'b10100;
    localparam logic [4:0] I_CMP  = 5'b10101;
    localparam logic [4:0] I_AND  = 5'b10110;
    localparam logic [4:0] I_MVN  = 5'b10111;
    localparam logic [4:0] I_LDR  = 5'b01100;
    localparam logic [4:0] I_STR  = 5'b10000;
    localparam logic [4:0] I_HALT = 5'b11100;

    typedef enum logic [3:0] {
        S_IDLE, S_IMM, S_GET_A, S_GET_B, S_ALU, S_WB, S_ADDR,
        S_LDADDR, S_GET_D, S_STB, S_MEM, S_LWB, S_HALT, S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [4:0]      instr;
    logic [CW-1:0]   tmo_cnt;
    logic [4:0]      live_instr;

    assign live_instr = {opcode, ALU_op};
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            instr   <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start)
                instr <= live_instr;
            // Counter only runs while in MEM, so it is always zero on MEM entry.
            if (state != S_MEM)
                tmo_cnt <= '0;
            else if (!mem_ack)
                tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (live_instr)
                        I_MOVI:               state_nx = S_IMM;
                        I_ADD, I_AND, I_CMP:  state_nx = S_GET_A;
                        I_MVN, I_MOV:         state_nx = S_GET_B;
                        I_LDR, I_STR:         state_nx = S_GET_A;
                        I_HALT:               state_nx = S_HALT;
                        default:              state_nx = S_ERR;
                    endcase
                end
            end
            S_IMM:    state_nx = S_IDLE;
            S_GET_A:  state_nx = (instr == I_LDR || instr == I_STR) ? S_ADDR : S_GET_B;
            S_GET_B:  state_nx = S_ALU;
            S_ALU:    state_nx = (instr == I_CMP) ? S_IDLE : S_WB;
            S_WB:     state_nx = S_IDLE;
            S_ADDR:   state_nx = S_LDADDR;
            S_LDADDR: state_nx = (instr == I_STR) ? S_GET_D : S_MEM;
            S_GET_D:  state_nx = S_STB;
            S_STB:    state_nx = S_MEM;
            S_MEM: begin
                // An ack in the final allowed cycle still completes the access.
                if (mem_ack)
                    state_nx = (instr == I_STR) ? S_IDLE : S_LWB;
                else if (tmo_cnt == TMO_LAST)
                    state_nx = S_ERR;
            end
            S_LWB:    state_nx = S_IDLE;
            S_HALT:   state_nx = S_HALT;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        waiting   = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        reg_sel   = 2'b00;
        wb_sel    = 2'b00;
        w_en      = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        en_addr   = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            S_IDLE:   waiting = 1'b1;
            S_IMM:    begin w_en = 1'b1; reg_sel = 2'b10; wb_sel = 2'b10; end
            S_GET_A:  begin reg_sel = 2'b10; en_A = 1'b1; end
            S_GET_B:  begin reg_sel = 2'b00; en_B = 1'b1; end
            S_ALU: begin
                en_C      = 1'b1;
                sel_A     = (instr == I_MVN || instr == I_MOV);
                en_status = (STATUS_ALL != 0) || (instr == I_CMP);
            end
            S_WB:     begin w_en = 1'b1; reg_sel = 2'b01; wb_sel = 2'b00; end
            S_ADDR:   begin en_C = 1'b1; sel_B = 1'b1; end
            S_LDADDR: en_addr = 1'b1;
            S_GET_D:  begin reg_sel = 2'b01; en_B = 1'b1; end
            S_STB:    begin en_C = 1'b1; sel_A = 1'b1; end
            S_MEM:    begin mem_req = 1'b1; mem_wr = (instr == I_STR); end
            S_LWB:    begin w_en = 1'b1; reg_sel = 2'b01; wb_sel = 2'b01; end
            S_HALT:   halted = 1'b1;
            S_ERR:    err = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller_mc.sv
// Directed bench for cpu_controller_mc: one instance with a short memory timeout,
// a second with status updates on every ALU cycle and the default timeout.
module tb_cpu_controller_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] ALU_op = 2'b00;
    logic       mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Packed output word: {waiting,halted,err,reg_sel,wb_sel,w_en,en_A,en_B,en_C,
    //                      en_status,en_addr,sel_A,sel_B,mem_req,mem_wr}
    localparam logic [16:0] O_IDLE    = 17'h10000;
    localparam logic [16:0] O_IMM     = 17'h02A00;
    localparam logic [16:0] O_GETA    = 17'h02100;
    localparam logic [16:0] O_GETB    = 17'h00080;
    localparam logic [16:0] O_ALU     = 17'h00040;
    localparam logic [16:0] O_ALU_ST  = 17'h00060;
    localparam logic [16:0] O_ALU_SA  = 17'h00048;
    localparam logic [16:0] O_WB      = 17'h01200;
    localparam logic [16:0] O_ADDR    = 17'h00044;
    localparam logic [16:0] O_LDADDR  = 17'h00010;
    localparam logic [16:0] O_GETD    = 17'h01080;
    localparam logic [16:0] O_STB     = 17'h00048;
    localparam logic [16:0] O_MEMR    = 17'h00002;
    localparam logic [16:0] O_MEMW    = 17'h00003;
    localparam logic [16:0] O_LWB     = 17'h01600;
    localparam logic [16:0] O_HALT    = 17'h08000;
    localparam logic [16:0] O_ERR     = 17'h04000;

    logic       waiting0, halted0, err0, w_en0, en_A0, en_B0, en_C0, en_status0;
    logic       en_addr0, sel_A0, sel_B0, mem_req0, mem_wr0;
    logic [1:0] reg_sel0, wb_sel0;
    logic [3:0] state_dbg0;
    logic       waiting1, halted1, err1, w_en1, en_A1, en_B1, en_C1, en_status1;
    logic       en_addr1, sel_A1, sel_B1, mem_req1, mem_wr1;
    logic [1:0] reg_sel1, wb_sel1;
    logic [3:0] state_dbg1;
    logic [16:0] o0, o1;

    assign o0 = {waiting0, halted0, err0, reg_sel0, wb_sel0, w_en0, en_A0, en_B0, en_C0,
                 en_status0, en_addr0, sel_A0, sel_B0, mem_req0, mem_wr0};
    assign o1 = {waiting1, halted1, err1, reg_sel1, wb_sel1, w_en1, en_A1, en_B1, en_C1,
                 en_status1, en_addr1, sel_A1, sel_B1, mem_req1, mem_wr1};

    cpu_controller_mc #(.MEM_TIMEOUT(4), .STATUS_ALL(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
        .mem_ack(mem_ack), .waiting(waiting0), .halted(halted0), .err(err0),
        .reg_sel(reg_sel0), .wb_sel(wb_sel0), .w_en(w_en0), .en_A(en_A0), .en_B(en_B0),
        .en_C(en_C0), .en_status(en_status0), .en_addr(en_addr0), .sel_A(sel_A0),
        .sel_B(sel_B0), .mem_req(mem_req0), .mem_wr(mem_wr0), .state_dbg(state_dbg0)
    );

    cpu_controller_mc #(.MEM_TIMEOUT(15), .STATUS_ALL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
        .mem_ack(mem_ack), .waiting(waiting1), .halted(halted1), .err(err1),
        .reg_sel(reg_sel1), .wb_sel(wb_sel1), .w_en(w_en1), .en_A(en_A1), .en_B(en_B1),
        .en_C(en_C1), .en_status(en_status1), .en_addr(en_addr1), .sel_A(sel_A1),
        .sel_B(sel_B1), .mem_req(mem_req1), .mem_wr(mem_wr1), .state_dbg(state_dbg1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [16:0] exp);
        chk({tag, "/a"}, o0, exp);
        chk({tag, "/b"}, o1, exp);
    endtask

    // Present an instruction for one accepting edge, then drop start.
    task automatic issue(input logic [4:0] ins);
        start = 1'b1;
        {opcode, ALU_op} = ins;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk2("reset", O_IDLE);
        tick();
        rst_n = 1'b1;
        tick();
        chk2("idle_after_reset", O_IDLE);

        // Reset in the middle of ADD (in the ALU cycle)
        issue(5'b10100);
        chk2("add_r_geta", O_GETA);
        tick();
        chk2("add_r_getb", O_GETB);
        tick();
        chk("add_r_alu_a", o0, O_ALU);
        chk("add_r_alu_b", o1, O_ALU_ST);
        rst_n = 1'b0;
        #1;
        chk2("async_reset", O_IDLE);
        #2;
        rst_n = 1'b1;
        tick();
        chk2("post_reset_idle", O_IDLE);
        issue(5'b11010);
        chk2("movi_imm", O_IMM);
        tick();
        chk2("movi_idle", O_IDLE);

        // ADD with inputs changed to HALT after start
        issue(5'b10100);
        chk2("add_geta", O_GETA);
        {opcode, ALU_op} = 5'b11100;
        tick();
        chk2("add_getb", O_GETB);
        tick();
        chk("add_alu_a", o0, O_ALU);
        chk("add_alu_b", o1, O_ALU_ST);
        tick();
        chk2("add_wb", O_WB);
        tick();
        chk2("add_idle", O_IDLE);

        // Back-to-back MOV imm with start held high
        start = 1'b1;
        {opcode, ALU_op} = 5'b11010;
        tick();
        chk2("b2b_imm1", O_IMM);
        tick();
        chk2("b2b_idle", O_IDLE);
        tick();
        chk2("b2b_imm2", O_IMM);
        start = 1'b0;
        tick();
        chk2("b2b_end", O_IDLE);

        // CMP: status only in ALU, no write-back
        issue(5'b10101);
        chk2("cmp_geta", O_GETA);
        tick();
        chk2("cmp_getb", O_GETB);
        tick();
        chk2("cmp_alu", O_ALU_ST);
        tick();
        chk2("cmp_idle", O_IDLE);

        // AND: status only on the STATUS_ALL instance
        issue(5'b10110);
        chk2("and_geta", O_GETA);
        tick();
        chk2("and_getb", O_GETB);
        tick();
        chk("and_alu_a", o0, O_ALU);
        chk("and_alu_b", o1, O_ALU_ST);
        tick();
        chk2("and_wb", O_WB);
        tick();
        chk2("and_idle", O_IDLE);

        // MVN: A operand forced to zero
        issue(5'b10111);
        chk2("mvn_getb", O_GETB);
        tick();
        chk("mvn_alu_a", o0, O_ALU_SA);
        chk("mvn_alu_b", o1, O_ALU_SA | 17'h00020);
        tick();
        chk2("mvn_wb", O_WB);
        tick();
        chk2("mvn_idle", O_IDLE);

        // MOV Rd,Rm
        issue(5'b11000);
        chk2("mov_getb", O_GETB);
        tick();
        chk("mov_alu_a", o0, O_ALU_SA);
        tick();
        chk2("mov_wb", O_WB);
        tick();
        chk2("mov_idle", O_IDLE);

        // LDR with ack on the third MEM cycle; an early ack before MEM is ignored
        issue(5'b01100);
        chk2("ldr_geta", O_GETA);
        mem_ack = 1'b1;
        tick();
        chk2("ldr_addr", O_ADDR);
        mem_ack = 1'b0;
        tick();
        chk2("ldr_ldaddr", O_LDADDR);
        tick();
        chk2("ldr_mem1", O_MEMR);
        tick();
        chk2("ldr_mem2", O_MEMR);
        tick();
        chk2("ldr_mem3", O_MEMR);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk2("ldr_lwb", O_LWB);
        tick();
        chk2("ldr_idle", O_IDLE);

        // STR with ack stuck low: short-timeout instance aborts after 4 MEM cycles,
        // default instance after 15
        issue(5'b10000);
        chk2("str_geta", O_GETA);
        tick();
        chk2("str_addr", O_ADDR);
        tick();
        chk2("str_ldaddr", O_LDADDR);
        tick();
        chk2("str_getd", O_GETD);
        tick();
        chk2("str_stb", O_STB);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("str_to_b_mem%0d", i), o1, O_MEMW);
            if (i <= 4)
                chk($sformatf("str_to_a_mem%0d", i), o0, O_MEMW);
            else if (i == 5)
                chk("str_to_a_err", o0, O_ERR);
            else
                chk($sformatf("str_to_a_idle%0d", i), o0, O_IDLE);
        end
        tick();
        chk("str_to_b_err", o1, O_ERR);
        tick();
        chk2("str_to_idle", O_IDLE);

        // STR with ack in the 4th MEM cycle: ack beats the timeout
        issue(5'b10000);
        chk2("str2_geta", O_GETA);
        tick();
        tick();
        tick();
        chk2("str2_getd", O_GETD);
        tick();
        chk2("str2_stb", O_STB);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk2($sformatf("str2_mem%0d", i), O_MEMW);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk2("str2_idle", O_IDLE);

        // Illegal instructions
        issue(5'b00011);
        chk2("ill_err", O_ERR);
        tick();
        chk2("ill_idle", O_IDLE);
        issue(5'b11111);
        chk2("ill2_err", O_ERR);
        tick();
        chk2("ill2_idle", O_IDLE);

        // HALT holds with start toggling, cleared only by reset
        issue(5'b11100);
        chk2("halt_enter", O_HALT);
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            {opcode, ALU_op} = 5'(i * 7);
            tick();
            chk2($sformatf("halt_hold%0d", i), O_HALT);
        end
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk2("halt_reset", O_IDLE);
        #2;
        rst_n = 1'b1;
        tick();
        chk2("halt_release_idle", O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
